// File: rtl/afe_serial_cfg.sv
// afe_serial_cfg: 3-wire serial register writer for CCD AFE chips.
// Snapshots a register bank on a start edge and shifts it out on SL/SCK/SDATA.
//
// Ports:
//   sys_clk, sys_rst    clock, synchronous active-high reset
//   cfg_start           rising edge starts a configuration pass
//   reg_data, reg_mask  register bank and per-register write enables
//   busy, done          pass in progress / one-cycle completion pulse
//   SCK, SDATA, SL      AFE serial pins (SCK idle low, SL active low)
module afe_serial_cfg #(
    parameter int ADDR_W    = 3,
    parameter int DATA_W    = 12,
    parameter int NUM_REGS  = 4,
    parameter int CLK_DIV   = 2,
    parameter int CONT_MODE = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         cfg_start,
    input  logic [NUM_REGS*DATA_W-1:0]   reg_data,
    input  logic [NUM_REGS-1:0]          reg_mask,
    output logic                         busy,
    output logic                         done,
    output logic                         SCK,
    output logic                         SDATA,
    output logic                         SL
);

    localparam int BANK_W = NUM_REGS * DATA_W;
    localparam int FW     = ADDR_W + BANK_W;
    localparam int BW     = $clog2(FW + 1);
    localparam int CW     = $clog2(2 * CLK_DIV + 1);
    localparam int IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [BW-1:0] N_LEN = (CONT_MODE != 0) ? BW'(FW) : BW'(ADDR_W + DATA_W);
    localparam logic [CW-1:0] PH_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(2 * CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_FINISH
    } state_t;

    // Frame laid out in transmit order: bit 0 goes out first.
    function automatic logic [FW-1:0] frame_of(input logic [BANK_W-1:0] bank,
                                               input logic [IW-1:0] idx);
        logic [FW-1:0]     f;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] v;
        f = '0;
        a = (CONT_MODE != 0) ? '0 : ADDR_W'(idx);
        for (int j = 0; j < ADDR_W; j++)
            f[j] = (LSB_FIRST != 0) ? a[j] : a[ADDR_W-1-j];
        if (CONT_MODE != 0) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                v = bank[r*DATA_W +: DATA_W];
                for (int j = 0; j < DATA_W; j++)
                    f[ADDR_W+r*DATA_W+j] = (LSB_FIRST != 0) ? v[j] : v[DATA_W-1-j];
            end
        end else begin
            v = bank[idx*DATA_W +: DATA_W];
            for (int j = 0; j < DATA_W; j++)
                f[ADDR_W+j] = (LSB_FIRST != 0) ? v[j] : v[DATA_W-1-j];
        end
        return f;
    endfunction

    function automatic logic [IW-1:0] low_idx(input logic [NUM_REGS-1:0] m);
        logic [IW-1:0] r;
        r = '0;
        for (int i = NUM_REGS - 1; i >= 0; i--)
            if (m[i]) r = IW'(i);
        return r;
    endfunction

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  hi_q, hi_d;
    logic [BW-1:0]         bits_q, bits_d;
    logic [FW-1:0]         sh_q, sh_d;
    logic [BANK_W-1:0]     bank_q, bank_d;
    logic [NUM_REGS-1:0]   pend_q, pend_d;
    logic                  start_q;
    logic                  sl_q, sl_d;
    logic                  sck_q, sck_d;
    logic                  sdata_q, sdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  start_edge;
    logic [BANK_W-1:0]     src_bank;
    logic [NUM_REGS-1:0]   src_pend;
    logic [IW-1:0]         nxt_idx;
    logic [FW-1:0]         nxt_frame;
    logic [NUM_REGS-1:0]   nxt_pend;

    assign start_edge = cfg_start & ~start_q;

    // Next frame source: live inputs when starting, snapshot between frames.
    always_comb begin
        src_bank  = (state_q == S_IDLE) ? reg_data : bank_q;
        src_pend  = '0;
        if (CONT_MODE == 0)
            src_pend = (state_q == S_IDLE) ? reg_mask : pend_q;
        nxt_idx   = low_idx(src_pend);
        nxt_frame = frame_of(src_bank, nxt_idx);
        nxt_pend  = src_pend & ~(NUM_REGS'(1) << nxt_idx);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        bits_d  = bits_q;
        sh_d    = sh_q;
        bank_d  = bank_q;
        pend_d  = pend_q;
        sl_d    = sl_q;
        sck_d   = sck_q;
        sdata_d = sdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    bank_d = reg_data;
                    busy_d = 1'b1;
                    if (CONT_MODE != 0 || reg_mask != '0) begin
                        state_d = S_SETUP;
                        cnt_d   = '0;
                        hi_d    = 1'b0;
                        sl_d    = 1'b0;
                        sck_d   = 1'b0;
                        sh_d    = nxt_frame;
                        sdata_d = nxt_frame[0];
                        bits_d  = N_LEN;
                        pend_d  = nxt_pend;
                    end else begin
                        // Nothing to send: one busy cycle, then finish.
                        state_d = S_GAP;
                        cnt_d   = GAP_LAST;
                        pend_d  = '0;
                    end
                end
            end
            S_SETUP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PH_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    hi_d    = 1'b0;
                end
            end
            S_SHIFT: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PH_LAST) begin
                    cnt_d = '0;
                    if (!hi_q) begin
                        hi_d  = 1'b1;
                        sck_d = 1'b1;
                    end else if (bits_q == BW'(1)) begin
                        state_d = S_HOLD;
                        hi_d    = 1'b0;
                        sck_d   = 1'b0;
                    end else begin
                        hi_d    = 1'b0;
                        sck_d   = 1'b0;
                        sh_d    = sh_q >> 1;
                        sdata_d = sh_q[1];
                        bits_d  = bits_q - BW'(1);
                    end
                end
            end
            S_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == PH_LAST) begin
                    cnt_d   = '0;
                    sl_d    = 1'b1;
                    sdata_d = 1'b0;
                    if (pend_q != '0) begin
                        state_d = S_GAP;
                    end else begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (pend_q == '0) begin
                        state_d = S_FINISH;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        hi_d    = 1'b0;
                        sl_d    = 1'b0;
                        sh_d    = nxt_frame;
                        sdata_d = nxt_frame[0];
                        bits_d  = N_LEN;
                        pend_d  = nxt_pend;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Start input is sampled even in reset so a level held high is not an edge.
    always_ff @(posedge sys_clk) begin
        start_q <= cfg_start;
        if (sys_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            bits_q  <= '0;
            sh_q    <= '0;
            bank_q  <= '0;
            pend_q  <= '0;
            sl_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdata_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            bits_q  <= bits_d;
            sh_q    <= sh_d;
            bank_q  <= bank_d;
            pend_q  <= pend_d;
            sl_q    <= sl_d;
            sck_q   <= sck_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign SCK   = sck_q;
    assign SDATA = sdata_q;
    assign SL    = sl_q;

endmodule

// File: tb/tb_afe_serial_cfg.sv
// tb_afe_serial_cfg: self-checking bench for afe_serial_cfg.
// Three instances: continuous LSB-first, individual frames, and fast MSB-first.
module tb_afe_serial_cfg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [3];
    logic        start [3];
    logic [47:0] rd    [3];
    logic [3:0]  mask  [3];
    logic        busy  [3];
    logic        done  [3];
    logic        sck   [3];
    logic        sdata [3];
    logic        sl    [3];

    int vectors     = 0;
    int miscompares = 0;

    afe_serial_cfg u_cont (
        .sys_clk(clk), .sys_rst(rst[0]), .cfg_start(start[0]),
        .reg_data(rd[0]), .reg_mask(mask[0]),
        .busy(busy[0]), .done(done[0]), .SCK(sck[0]), .SDATA(sdata[0]), .SL(sl[0])
    );

    afe_serial_cfg #(.CONT_MODE(0)) u_ind (
        .sys_clk(clk), .sys_rst(rst[1]), .cfg_start(start[1]),
        .reg_data(rd[1]), .reg_mask(mask[1]),
        .busy(busy[1]), .done(done[1]), .SCK(sck[1]), .SDATA(sdata[1]), .SL(sl[1])
    );

    afe_serial_cfg #(.CLK_DIV(1), .LSB_FIRST(0)) u_msb (
        .sys_clk(clk), .sys_rst(rst[2]), .cfg_start(start[2]),
        .reg_data(rd[2]), .reg_mask(mask[2]),
        .busy(busy[2]), .done(done[2]), .SCK(sck[2]), .SDATA(sdata[2]), .SL(sl[2])
    );

    // Pin monitor: decodes frames from the serial pins on the falling clock edge.
    int          cyc        = 0;
    int          low_c  [3] = '{default: 0};
    int          high_c [3] = '{default: 0};
    int          cap_n  [3] = '{default: 0};
    int          gap_rec[3] = '{default: 0};
    logic [63:0] cap    [3] = '{default: '0};
    logic [63:0] fb  [3][8];
    int          fn  [3][8];
    int          fl  [3][8];
    int          fg  [3][8];
    int          frames   [3] = '{default: 0};
    int          dones    [3] = '{default: 0};
    int          brise    [3] = '{default: 0};
    int          blen_c   [3] = '{default: 0};
    int          blen     [3] = '{default: 0};
    int          viol     [3] = '{default: 0};
    int          last_rise[3] = '{default: 0};
    int          last_done[3] = '{default: 0};
    int          last_bfall[3] = '{default: 0};
    logic        psl  [3] = '{default: 1'b1};
    logic        psck [3] = '{default: 1'b0};
    logic        psd  [3] = '{default: 1'b0};
    logic        pbusy[3] = '{default: 1'b0};

    always @(negedge clk) begin
        cyc <= cyc + 1;
        for (int d = 0; d < 3; d++) begin
            if (!sl[d]) begin
                if (psl[d]) begin
                    cap_n[d]   <= 0;
                    cap[d]     <= '0;
                    low_c[d]   <= 1;
                    gap_rec[d] <= high_c[d];
                end else begin
                    low_c[d] <= low_c[d] + 1;
                    if (sck[d] && !psck[d] && cap_n[d] < 64) begin
                        cap[d][cap_n[d]] <= sdata[d];
                        cap_n[d]         <= cap_n[d] + 1;
                    end
                end
            end else begin
                if (!psl[d]) begin
                    fb[d][frames[d]%8] <= cap[d];
                    fn[d][frames[d]%8] <= cap_n[d];
                    fl[d][frames[d]%8] <= low_c[d];
                    fg[d][frames[d]%8] <= gap_rec[d];
                    frames[d]          <= frames[d] + 1;
                    last_rise[d]       <= cyc;
                    high_c[d]          <= 1;
                end else begin
                    high_c[d] <= high_c[d] + 1;
                end
                if (sck[d]) viol[d] <= viol[d] + 1;
            end
            if (psck[d] && sck[d] && sdata[d] !== psd[d]) viol[d] <= viol[d] + 1;
            if (done[d]) begin
                dones[d]     <= dones[d] + 1;
                last_done[d] <= cyc;
            end
            if (busy[d]) begin
                if (!pbusy[d]) begin
                    brise[d]  <= brise[d] + 1;
                    blen_c[d] <= 1;
                end else begin
                    blen_c[d] <= blen_c[d] + 1;
                end
            end else if (pbusy[d]) begin
                blen[d]       <= blen_c[d];
                last_bfall[d] <= cyc;
            end
            psl[d]   <= sl[d];
            psck[d]  <= sck[d];
            psd[d]   <= sdata[d];
            pbusy[d] <= busy[d];
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    // Reference: append a field in transmit order.
    function automatic void add_field(inout logic [63:0] v, inout int n,
                                      input int val, input int w, input bit lsb);
        for (int j = 0; j < w; j++) begin
            v[n] = lsb ? val[j] : val[w-1-j];
            n++;
        end
    endfunction

    task automatic wait_done(input int d, input int target, input string tag);
        int n;
        n = 0;
        while (dones[d] < target && n < 3000) begin
            tick(1);
            n++;
        end
        check({tag, "_done_seen"}, 64'(dones[d] >= target), 64'd1);
    endtask

    task automatic cont_pass(input int d, input bit lsb, input int cdiv,
                             input logic [47:0] data, input bit extra, input string tag);
        logic [63:0] e;
        int n, f0, d0, b0, ix;
        e = '0;
        n = 0;
        add_field(e, n, 0, 3, lsb);
        for (int r = 0; r < 4; r++) add_field(e, n, int'(data[r*12 +: 12]), 12, lsb);
        rd[d] = data;
        f0 = frames[d];
        d0 = dones[d];
        b0 = brise[d];
        start[d] = 1'b1;
        tick(1);
        start[d] = 1'b0;
        tick(9);
        check({tag, "_busy_mid"}, 64'(busy[d]), 64'd1);
        if (extra) begin
            start[d] = 1'b1;
            tick(1);
            start[d] = 1'b0;
        end
        tick(10);
        rd[d] = rnd48();
        if (extra) begin
            tick(80);
            start[d] = 1'b1;
            tick(1);
            start[d] = 1'b0;
            check({tag, "_busy_late"}, 64'(busy[d]), 64'd1);
        end
        wait_done(d, d0 + 1, tag);
        tick(extra ? 20 : 3);
        ix = f0 % 8;
        check({tag, "_frames"}, 64'(frames[d] - f0), 64'd1);
        check({tag, "_dones"}, 64'(dones[d] - d0), 64'd1);
        check({tag, "_busy_rises"}, 64'(brise[d] - b0), 64'd1);
        check({tag, "_nbits"}, 64'(fn[d][ix]), 64'(n));
        check({tag, "_bits"}, fb[d][ix], e);
        check({tag, "_sl_low"}, 64'(fl[d][ix]), 64'(cdiv * (2 * n + 2)));
        check({tag, "_done_at_sl_rise"}, 64'(last_done[d]), 64'(last_rise[d]));
        check({tag, "_pin_rules"}, 64'(viol[d]), 64'd0);
    endtask

    task automatic ind_pass(input logic [47:0] data, input logic [3:0] m, input string tag);
        logic [63:0] e;
        int n, f0, d0, b0, k, cnt, ix;
        rd[1] = data;
        mask[1] = m;
        f0 = frames[1];
        d0 = dones[1];
        b0 = brise[1];
        start[1] = 1'b1;
        tick(1);
        start[1] = 1'b0;
        tick(3);
        rd[1] = rnd48();
        mask[1] = 4'($urandom);
        wait_done(1, d0 + 1, tag);
        tick(3);
        cnt = 0;
        for (int i = 0; i < 4; i++) if (m[i]) cnt++;
        check({tag, "_frames"}, 64'(frames[1] - f0), 64'(cnt));
        check({tag, "_busy_rises"}, 64'(brise[1] - b0), 64'd1);
        check({tag, "_pin_rules"}, 64'(viol[1]), 64'd0);
        if (m == 4'd0) begin
            check({tag, "_busy_len"}, 64'(blen[1]), 64'd1);
            check({tag, "_done_at_busy_fall"}, 64'(last_done[1]), 64'(last_bfall[1]));
        end else begin
            check({tag, "_done_at_sl_rise"}, 64'(last_done[1]), 64'(last_rise[1]));
        end
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) begin
                e = '0;
                n = 0;
                add_field(e, n, i, 3, 1'b1);
                add_field(e, n, int'(data[i*12 +: 12]), 12, 1'b1);
                ix = (f0 + k) % 8;
                check({tag, "_bits"}, fb[1][ix], e);
                check({tag, "_nbits"}, 64'(fn[1][ix]), 64'(n));
                check({tag, "_sl_low"}, 64'(fl[1][ix]), 64'(2 * (2 * n + 2)));
                if (k > 0) check({tag, "_gap"}, 64'(fg[1][ix]), 64'd4);
                k++;
            end
        end
    endtask

    initial begin
        int n, d0;
        logic [3:0] m;
        for (int d = 0; d < 3; d++) begin
            rst[d]   = 1'b1;
            start[d] = 1'b0;
            rd[d]    = '0;
            mask[d]  = '0;
        end
        tick(3);
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        tick(2);
        for (int d = 0; d < 3; d++) begin
            check("rst_sl", 64'(sl[d]), 64'd1);
            check("rst_sck", 64'(sck[d]), 64'd0);
            check("rst_sdata", 64'(sdata[d]), 64'd0);
            check("rst_busy", 64'(busy[d]), 64'd0);
            check("rst_done", 64'(done[d]), 64'd0);
        end

        cont_pass(0, 1'b1, 2, {12'h3FF, 12'h080, 12'h005, 12'h011}, 1'b0, "cont_dir");
        ind_pass(rnd48(), 4'b0101, "ind_0101");
        cont_pass(0, 1'b1, 2, rnd48(), 1'b1, "cont_ignore_edges");
        cont_pass(0, 1'b1, 2, rnd48(), 1'b0, "cont_after_ignore");

        // Reset in the middle of a frame.
        rd[0] = rnd48();
        d0 = dones[0];
        start[0] = 1'b1;
        tick(1);
        start[0] = 1'b0;
        tick(2);
        n = 0;
        while (cap_n[0] < 20 && n < 1000) begin
            tick(1);
            n++;
        end
        check("rst_mid_reached_bit20", 64'(cap_n[0]), 64'd20);
        rst[0] = 1'b1;
        tick(1);
        rst[0] = 1'b0;
        check("rst_mid_sl", 64'(sl[0]), 64'd1);
        check("rst_mid_sck", 64'(sck[0]), 64'd0);
        check("rst_mid_sdata", 64'(sdata[0]), 64'd0);
        check("rst_mid_busy", 64'(busy[0]), 64'd0);
        check("rst_mid_done", 64'(done[0]), 64'd0);
        tick(10);
        check("rst_mid_no_done", 64'(dones[0] - d0), 64'd0);
        cont_pass(0, 1'b1, 2, rnd48(), 1'b0, "cont_after_rst");

        cont_pass(2, 1'b0, 1, {rnd48() >> 12, 12'h801} , 1'b0, "msb_801");
        ind_pass(rnd48(), 4'b0000, "ind_empty");

        for (int i = 0; i < 3; i++) cont_pass(0, 1'b1, 2, rnd48(), 1'b0, "cont_rand");
        for (int i = 0; i < 4; i++) begin
            m = 4'($urandom);
            ind_pass(rnd48(), m, "ind_rand");
        end
        ind_pass(rnd48(), 4'b1111, "ind_all");
        for (int i = 0; i < 2; i++) cont_pass(2, 1'b0, 1, rnd48(), 1'b0, "msb_rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
